// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR word controller.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GEN  = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [7:0] LFSR_DEFAULT_TAP  = 8'hB8;
    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'h01;

    // Width needed to express a bit count from 0 to w inclusive.
    function automatic int len_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lfsr_word_pack.sv
// Packs serial LFSR bits LSB-first into a word; flags the last sample of a word.
module lfsr_word_pack #(
    parameter int wbits = 8,
    parameter int LW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic [LW-1:0]    len_i,
    output logic [wbits-1:0] data_o,
    output logic             done_o
);

    logic [wbits-1:0] data_q, data_d;
    logic [LW-1:0]    idx_q, idx_d;

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (clear_i) begin
            data_d = '0;
            idx_d  = '0;
        end else if (shift_i) begin
            data_d = data_q | (wbits'(bit_i) << idx_q);
            idx_d  = idx_q + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign data_o = data_q;
    assign done_o = shift_i && ((idx_q + LW'(1)) == len_i);

endmodule

// File: rtl/lfsr_word_ctrl.sv
// Sequences reseed/shift of an external Fibonacci LFSR and returns packed words over val/rdy.
// Optional zero-seed guard: define LFSR_ZERO_SEED_GUARD_EN.
module lfsr_word_ctrl
    import lfsr_pkg::*;
#(
    parameter int               nbits        = 8,
    parameter int               wbits        = 8,
    parameter logic [nbits-1:0] DEFAULT_TAP  = LFSR_DEFAULT_TAP,
    parameter logic [nbits-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
    parameter int               LW           = len_width(wbits)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_val,
    output logic             cfg_rdy,
    input  logic [nbits-1:0] cfg_tap,
    input  logic [nbits-1:0] cfg_seed,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [LW-1:0]    req_len,
    input  logic             req_reseed,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [wbits-1:0] resp_data,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic [nbits-1:0] lfsr_tap,
    output logic [nbits-1:0] lfsr_seed,
    input  logic             lfsr_out,
    output logic             seed_fix
);

    state_e           state_q, state_d;
    logic [nbits-1:0] tap_q, seed_q;
    logic [LW-1:0]    len_q, len_d;
    logic             idle, req_fire, cfg_fire, gen_done;

    assign idle     = (state_q == IDLE);
    assign req_fire = idle && req_val;
    assign cfg_fire = idle && cfg_val;

    // Zero or oversized lengths collapse to a full word.
    assign len_d = ((req_len == '0) || (req_len > LW'(wbits))) ? LW'(wbits) : req_len;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_val) state_d = req_reseed ? LOAD : GEN;
            LOAD:    state_d = GEN;
            GEN:     if (gen_done) state_d = RESP;
            RESP:    if (resp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tap_q   <= DEFAULT_TAP;
            seed_q  <= DEFAULT_SEED;
            len_q   <= LW'(wbits);
        end else begin
            state_q <= state_d;
            if (cfg_fire) begin
                tap_q  <= cfg_tap;
                seed_q <= cfg_seed;
            end
            if (req_fire) len_q <= len_d;
        end
    end

    lfsr_word_pack #(
        .wbits (wbits),
        .LW    (LW)
    ) u_pack (
        .clk     (clk),
        .rst     (rst),
        .clear_i (req_fire),
        .shift_i (lfsr_en),
        .bit_i   (lfsr_out),
        .len_i   (len_q),
        .data_o  (resp_data),
        .done_o  (gen_done)
    );

    assign cfg_rdy   = idle;
    assign req_rdy   = idle;
    assign resp_val  = (state_q == RESP);
    assign lfsr_load = (state_q == LOAD);
    assign lfsr_en   = (state_q == GEN);
    assign lfsr_tap  = tap_q;

`ifdef LFSR_ZERO_SEED_GUARD_EN
    logic seed_fix_q;

    // An all-zero seed would lock the LFSR; substitute 1 and remember it happened.
    assign lfsr_seed = (seed_q == '0) ? nbits'(1) : seed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_fix_q <= 1'b0;
        end else if (lfsr_load && (seed_q == '0)) begin
            seed_fix_q <= 1'b1;
        end
    end

    assign seed_fix = seed_fix_q;
`else
    assign lfsr_seed = seed_q;
    assign seed_fix  = 1'b0;
`endif

endmodule
